result_display_driver: RTL and testbench

Downstream consumer of the systolic-array controllers and `sub_controller`. Captures the four result elements (C11, C12, C21, C22) produced by each array mode (single, 2by2, 3by3) into a per-mode result buffer. Selects the mode given by `display_selection` and steps through the four elements with the `left` button pulse. Drives a time-multiplexed, active-low 7-segment display showing the selected element in hex.

---
 rtl/display_pkg.sv | 21 ++
 rtl/hex_to_7seg.sv | 10 +
 rtl/result_display_driver.sv | 101 ++++++++++
 tb/tb_result_display_driver.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared encodings and segment patterns for the result display.
// Contents: mode encodings, element addresses, blank pattern and the
// hex-to-segment table (active-low, bit order {g,f,e,d,c,b,a}).
package display_pkg;
   typedef enum logic [1:0] {
      MODE_NONE   = 2'd0,
      MODE_SINGLE = 2'd1,
      MODE_2BY2   = 2'd2,
      MODE_3BY3   = 2'd3
   } mode_e;
   localparam logic [1:0] C11 = 2'd0;
   localparam logic [1:0] C12 = 2'd1;
   localparam logic [1:0] C21 = 2'd2;
   localparam logic [1:0] C22 = 2'd3;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   // Entry n occupies bits [7n+6:7n]; B and D use the lowercase glyphs.
   localparam logic [111:0] HEX_SEG = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };
endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational nibble to active-low 7-segment pattern.
// Ports: nib (4-bit value in), seg_n (7-bit pattern out, {g,f,e,d,c,b,a}).
module hex_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg_n
);
   assign seg_n = HEX_SEG[7*nib +: 7];
endmodule

// File: rtl/result_display_driver.sv
// result_display_driver: buffers per-mode C11..C22 results and scans the
// selected element in hex onto a multiplexed active-low 7-segment display.
// Ports: clk, rstb (async active-low); display_selection; write port
// wr_en/wr_mode/wr_addr/wr_data; clear; left (element step pulse);
// outputs seg_n, an_n, elem_idx, elem_valid (all registered).
// Option: define RESULT_DISPLAY_LZB_EN for leading-zero blanking.
module result_display_driver
   import display_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int SCAN_DIV = 50000
)(
   input  logic                  clk,
   input  logic                  rstb,
   input  logic [1:0]            display_selection,
   input  logic                  wr_en,
   input  logic [1:0]            wr_mode,
   input  logic [1:0]            wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  clear,
   input  logic                  left,
   output logic [6:0]            seg_n,
   output logic [DATA_W/4-1:0]   an_n,
   output logic [1:0]            elem_idx,
   output logic                  elem_valid
);
   localparam int DIGITS = DATA_W / 4;
   localparam int DIV_W  = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int PTR_W  = DIGITS > 1 ? $clog2(DIGITS) : 1;
   // Buffer entries are addressed {mode, addr}; mode 0 entries are never written.
   logic [DATA_W-1:0] data_q [16];
   logic [DATA_W-1:0] data_d [16];
   logic [15:0]       vld_q, vld_d;
   logic [1:0]        sel_q, idx_q, idx_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [6:0]        seg_q, seg_d, hex_seg;
   logic [DIGITS-1:0] an_q, an_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] shown;
   logic [3:0]        nib;
   logic              blank, tick, wr;
   hex_to_7seg u_hex (
      .nib   (nib),
      .seg_n (hex_seg)
   );
   // Display path reads only registered state, so segments follow a write,
   // step or selection change one edge later, aligned with an_n.
   always_comb begin
      shown = data_q[{sel_q, idx_q}];
      nib   = 4'(shown >> {ptr_q, 2'b00});
      blank = sel_q == MODE_NONE || !vld_q[{sel_q, idx_q}];
`ifdef RESULT_DISPLAY_LZB_EN
      blank = blank || (ptr_q != '0 && (shown >> {ptr_q, 2'b00}) == '0);
`endif
   end
   always_comb begin
      wr     = wr_en && wr_mode != MODE_NONE;
      data_d = data_q;
      vld_d  = clear ? '0 : vld_q;
      if (wr) begin
         data_d[{wr_mode, wr_addr}] = wr_data;
         vld_d[{wr_mode, wr_addr}]  = 1'b1;
      end
      idx_d   = display_selection != sel_q ? 2'd0 : idx_q + 2'(left);
      // elem_valid tracks the index and buffer state that this edge installs.
      valid_d = display_selection != MODE_NONE && vld_d[{display_selection, idx_d}];
      tick    = div_q == DIV_W'(SCAN_DIV - 1);
      div_d   = tick ? '0 : div_q + DIV_W'(1);
      ptr_d   = !tick ? ptr_q : ptr_q == PTR_W'(DIGITS - 1) ? '0 : ptr_q + PTR_W'(1);
      seg_d   = blank ? SEG_BLANK : hex_seg;
      an_d    = ~(DIGITS'(1) << ptr_q);
   end
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < 16; i++) data_q[i] <= '0;
         vld_q   <= '0;
         sel_q   <= '0;
         idx_q   <= '0;
         div_q   <= '0;
         ptr_q   <= '0;
         seg_q   <= SEG_BLANK;
         an_q    <= '1;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         vld_q   <= vld_d;
         sel_q   <= display_selection;
         idx_q   <= idx_d;
         div_q   <= div_d;
         ptr_q   <= ptr_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         valid_q <= valid_d;
      end
   end
   assign seg_n      = seg_q;
   assign an_n       = an_q;
   assign elem_idx   = idx_q;
   assign elem_valid = valid_q;
endmodule

// File: tb/tb_result_display_driver.sv
// tb_result_display_driver: randomized scoreboard bench for result_display_driver.
module tb_result_display_driver;
   localparam int DW = 16, SD = 4, DIG = 4;
   logic        clk = 1'b0, rstb = 1'b0;
   logic [1:0]  display_selection = '0, wr_mode = '0, wr_addr = '0;
   logic        wr_en = 1'b0, clear = 1'b0, left = 1'b0;
   logic [15:0] wr_data = '0;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic [1:0]  elem_idx;
   logic        elem_valid;
   result_display_driver #(.DATA_W(DW), .SCAN_DIV(SD)) dut (
      .clk               (clk),
      .rstb              (rstb),
      .display_selection (display_selection),
      .wr_en             (wr_en),
      .wr_mode           (wr_mode),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .clear             (clear),
      .left              (left),
      .seg_n             (seg_n),
      .an_n              (an_n),
      .elem_idx          (elem_idx),
      .elem_valid        (elem_valid)
   );
   always #5 clk = ~clk;
   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] an;
      logic [1:0] idx;
      logic       val;
   } exp_t;
   exp_t q[$];
   int total = 0, bad = 0, cyc = 0;
   bit [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [15:0] m_data [4][4];
   bit          m_vld [4][4];
   int          m_idx, m_psel, m_n;
   logic [1:0]  rs;
   logic [15:0] rd;
   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask
   task automatic check_reset();
      check("rst_seg", 16'(seg_n), 16'h7F);
      check("rst_an", 16'(an_n), 16'hF);
      check("rst_idx", 16'(elem_idx), 16'h0);
      check("rst_valid", 16'(elem_valid), 16'h0);
   endtask
   function automatic void model_reset();
      foreach (m_vld[i, j]) begin
         m_vld[i][j]  = 1'b0;
         m_data[i][j] = '0;
      end
      m_idx = 0;
      m_psel = 0;
      m_n = 0;
   endfunction
   function automatic logic [6:0] disp(int sel, int idx, int p);
      logic [15:0] v;
      if (sel == 0 || !m_vld[sel][idx]) return 7'h7F;
      v = m_data[sel][idx] >> (4 * p);
`ifdef RESULT_DISPLAY_LZB_EN
      if (p > 0 && v == 16'h0) return 7'h7F;
`endif
      return font[v[3:0]];
   endfunction
   task automatic step(input logic [1:0] sel, input bit we, input logic [1:0] wm,
                       input logic [1:0] wa, input logic [15:0] wd, input bit clr, input bit lf);
      exp_t e;
      int   p;
      display_selection = sel;
      wr_en = we;
      wr_mode = wm;
      wr_addr = wa;
      wr_data = wd;
      clear = clr;
      left = lf;
      p = (m_n / SD) % DIG;
      e.an  = 4'hF ^ (4'h1 << p);
      e.seg = disp(m_psel, m_idx, p);
      if (clr) foreach (m_vld[i, j]) m_vld[i][j] = 1'b0;
      if (we && wm != 2'd0) begin
         m_data[wm][wa] = wd;
         m_vld[wm][wa]  = 1'b1;
      end
      m_idx  = (int'(sel) != m_psel) ? 0 : lf ? (m_idx + 1) % 4 : m_idx;
      m_psel = int'(sel);
      m_n++;
      e.idx = m_idx[1:0];
      e.val = sel != 2'd0 && m_vld[sel][m_idx];
      q.push_back(e);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      clear = 1'b0;
      left = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) step(m_psel[1:0], 1'b0, 2'd0, 2'd0, 16'h0, 1'b0, 1'b0);
   endtask
   task automatic random_run(input int n);
      for (int k = 0; k < n; k++) begin
         rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : m_psel[1:0];
         rd = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
         step(rs, $urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              rd, $urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0);
      end
   endtask
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("seg", 16'(seg_n), 16'(e.seg));
            check("an", 16'(an_n), 16'(e.an));
            check("idx", 16'(elem_idx), 16'(e.idx));
            check("valid", 16'(elem_valid), 16'(e.val));
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
   initial begin
      model_reset();
      repeat (3) begin
         @(negedge clk);
         check_reset();
      end
      rstb = 1'b1;
      idle(2);
      step(2'd0, 1'b1, 2'd2, 2'd1, 16'h12AB, 1'b0, 1'b0);
      step(2'd2, 1'b0, 2'd0, 2'd0, 16'h0, 1'b0, 1'b0);
      step(2'd2, 1'b0, 2'd0, 2'd0, 16'h0, 1'b0, 1'b1);
      idle(20);
      repeat (4) begin
         step(2'd2, 1'b0, 2'd0, 2'd0, 16'h0, 1'b0, 1'b1);
         idle(2);
      end
      step(2'd1, 1'b0, 2'd0, 2'd0, 16'h0, 1'b0, 1'b1);
      idle(2);
      step(2'd3, 1'b0, 2'd0, 2'd0, 16'h0, 1'b0, 1'b0);
      idle(16);
      step(2'd3, 1'b1, 2'd3, 2'd0, 16'hBEEF, 1'b1, 1'b0);
      idle(4);
      step(2'd2, 1'b0, 2'd0, 2'd0, 16'h0, 1'b0, 1'b0);
      step(2'd2, 1'b0, 2'd0, 2'd0, 16'h0, 1'b0, 1'b1);
      idle(2);
      step(2'd2, 1'b1, 2'd1, 2'd0, 16'h0005, 1'b0, 1'b0);
      step(2'd1, 1'b1, 2'd0, 2'd0, 16'hFFFF, 1'b0, 1'b0);
      idle(20);
      random_run(400);
      @(negedge clk);
      #2 rstb = 1'b0;
      #1 check_reset();
      model_reset();
      @(posedge clk);
      #1 check_reset();
      @(negedge clk);
      rstb = 1'b1;
      idle(3);
      step(2'd3, 1'b1, 2'd3, 2'd2, 16'h0D0C, 1'b0, 1'b0);
      step(2'd3, 1'b0, 2'd0, 2'd0, 16'h0, 1'b0, 1'b1);
      step(2'd3, 1'b0, 2'd0, 2'd0, 16'h0, 1'b0, 1'b1);
      idle(18);
      random_run(200);
      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d exp=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
